// File: rtl/lutram_mw_1r_pkg.sv
// Shared constants and helpers for the multi-write LUTRAM slice: vendor selection
// and live-value-table width sizing.
package lutram_mw_1r_pkg;

   typedef enum logic {XILINX, INTEL} fpga_vendor_t;

   localparam fpga_vendor_t FPGA_VENDOR_DEFAULT = XILINX;

   // A single write port still needs a 1-bit LVT entry so the array is never zero-width.
   function automatic int lvt_width(input int num_ports);
      return (num_ports > 1) ? $clog2(num_ports) : 1;
   endfunction

endpackage

// File: rtl/lutram_mw_1r_bank.sv
// One write port, one asynchronous read port LUTRAM bank; used as the per-port
// storage bank of lutram_mw_1r on INTEL targets.
module lutram_1w_1r #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 32
) (
   input  logic                     clk,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   input  logic                     ram_write,
   input  logic [WIDTH-1:0]         new_ram_data,
   output logic [WIDTH-1:0]         ram_data_out
);

   logic [WIDTH-1:0] mem_q [DEPTH];

   // NOTE: the storage array has no reset branch; a reset would turn it into flops
   // instead of LUTRAM, so the owner clears it with a sequencer after reset.
   // NOTE: sequential state uses <= so every reader sees the pre-edge value.
   always_ff @(posedge clk) begin
      if (ram_write) mem_q[waddr] <= new_ram_data;
   end

   assign ram_data_out = mem_q[raddr];

endmodule

// File: rtl/lutram_mw_1r.sv
// Multi-write, single-read LUTRAM: one bank per write port plus a flop live value
// table recording which bank holds the latest value of each entry.
module lutram_mw_1r
   import lutram_mw_1r_pkg::*;
#(
   parameter int           WIDTH           = 32,
   parameter int           DEPTH           = 32,
   parameter int           NUM_WRITE_PORTS = 2,
   parameter fpga_vendor_t FPGA_VENDOR     = FPGA_VENDOR_DEFAULT
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [$clog2(DEPTH)-1:0]   waddr        [NUM_WRITE_PORTS],
   input  logic [NUM_WRITE_PORTS-1:0] ram_write,
   input  logic [WIDTH-1:0]           new_ram_data [NUM_WRITE_PORTS],
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]           ram_data_out,
   output logic                       init_done
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int LVT_W  = lvt_width(NUM_WRITE_PORTS);

   typedef enum logic {CLEAR, READY} clear_state_t;

   clear_state_t      state_q;
   logic [ADDR_W-1:0] clear_addr_q;
   logic              init_done_q;
   logic              clearing;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= CLEAR;
         clear_addr_q <= '0;
         init_done_q  <= 1'b0;
      end else begin
         case (state_q)
            CLEAR: begin
               clear_addr_q <= clear_addr_q + 1'b1;
               if (clear_addr_q == ADDR_W'(DEPTH - 1)) begin
                  state_q     <= READY;
                  init_done_q <= 1'b1;
               end
            end
            READY: state_q <= READY;
            default: state_q <= CLEAR;
         endcase
      end
   end

   assign clearing  = (state_q == CLEAR);
   assign init_done = init_done_q;

   logic [WIDTH-1:0] bank_rdata [NUM_WRITE_PORTS];

   for (genvar i = 0; i < NUM_WRITE_PORTS; i++) begin : g_bank
      logic              bank_we;
      logic [ADDR_W-1:0] bank_waddr;
      logic [WIDTH-1:0]  bank_wdata;

      // The clear sequencer owns every bank write port until the table is ready.
      assign bank_we    = clearing | (init_done_q & ram_write[i]);
      assign bank_waddr = clearing ? clear_addr_q : waddr[i];
      assign bank_wdata = clearing ? '0 : new_ram_data[i];

      if (FPGA_VENDOR == INTEL) begin : g_intel
         lutram_1w_1r #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) bank_i (
            .clk          (clk),
            .waddr        (bank_waddr),
            .raddr        (raddr),
            .ram_write    (bank_we),
            .new_ram_data (bank_wdata),
            .ram_data_out (bank_rdata[i])
         );
      end else begin : g_xilinx
         logic [WIDTH-1:0] mem_q [DEPTH];

         always_ff @(posedge clk) begin
            if (bank_we) mem_q[bank_waddr] <= bank_wdata;
         end

         assign bank_rdata[i] = mem_q[raddr];
      end
   end

   logic [LVT_W-1:0] lvt_q [DEPTH];

   // Ports are visited in ascending order, so on a shared address the highest index lands last.
   always_ff @(posedge clk) begin
      if (clearing) begin
         lvt_q[clear_addr_q] <= '0;
      end else if (init_done_q) begin
         for (int i = 0; i < NUM_WRITE_PORTS; i++) begin
            if (ram_write[i]) lvt_q[waddr[i]] <= LVT_W'(i);
         end
      end
   end

   // NOTE: the output gets a default before the conditional so no latch is inferred.
   always_comb begin
      ram_data_out = '0;
      if (init_done_q) ram_data_out = bank_rdata[lvt_q[raddr]];
   end

endmodule

// File: tb/tb_lutram_mw_1r.sv
// Directed plus randomized bench for lutram_mw_1r, checked against a plain array
// model of "last write wins, cleared on every reset, idle for DEPTH cycles".
module tb_lutram_mw_1r;

   localparam int WIDTH = 32;
   localparam int DEPTH = 32;
   localparam int NWP   = 2;
   localparam int AW    = $clog2(DEPTH);

   logic             clk = 1'b0;
   logic             rst;
   logic [AW-1:0]    waddr        [NWP];
   logic [NWP-1:0]   ram_write;
   logic [WIDTH-1:0] new_ram_data [NWP];
   logic [AW-1:0]    raddr;
   logic [WIDTH-1:0] ram_data_out;
   logic             init_done;

   int compared   = 0;
   int mismatched = 0;

   logic [WIDTH-1:0] model_mem [DEPTH];
   int               cycles_since_rst = 0;

   always #5 clk = ~clk;

   lutram_mw_1r #(
      .WIDTH           (WIDTH),
      .DEPTH           (DEPTH),
      .NUM_WRITE_PORTS (NWP)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .waddr        (waddr),
      .ram_write    (ram_write),
      .new_ram_data (new_ram_data),
      .raddr        (raddr),
      .ram_data_out (ram_data_out),
      .init_done    (init_done)
   );

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no end of run, expected $finish before time limit");
      $fatal(1, "watchdog");
   end

   function automatic logic model_ready();
      return cycles_since_rst >= DEPTH;
   endfunction

   function automatic logic [WIDTH-1:0] model_read(input logic [AW-1:0] a);
      return model_ready() ? model_mem[a] : '0;
   endfunction

   task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare both outputs with the model for the inputs currently presented.
   task automatic sample(input string tag);
      #1;
      check({tag, "_done"}, {{(WIDTH-1){1'b0}}, init_done}, {{(WIDTH-1){1'b0}}, model_ready()});
      check({tag, "_rd"}, ram_data_out, model_read(raddr));
   endtask

   // Update the model with what the coming edge does, then advance past it.
   task automatic tick();
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) model_mem[a] = '0;
         cycles_since_rst = 0;
      end else if (model_ready()) begin
         for (int p = 0; p < NWP; p++)
            if (ram_write[p]) model_mem[waddr[p]] = new_ram_data[p];
      end else begin
         cycles_since_rst++;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      ram_write = '0;
      for (int p = 0; p < NWP; p++) begin
         waddr[p]        = '0;
         new_ram_data[p] = '0;
      end
   endtask

   task automatic wr(input int port, input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
      ram_write[port]    = 1'b1;
      waddr[port]        = a;
      new_ram_data[port] = d;
   endtask

   initial begin
      rst   = 1'b1;
      raddr = '0;
      idle();
      tick();
      tick();
      sample("reset");

      // Clear window: init_done low for exactly DEPTH cycles; an early write is dropped.
      rst = 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
         if (c == 1) wr(0, 5'd2, 32'h77);
         raddr = AW'($urandom_range(0, DEPTH - 1));
         sample("clear");
         tick();
         idle();
      end
      sample("ready");
      for (int a = 0; a < DEPTH; a++) begin
         raddr = AW'(a);
         sample("init_rd");
      end
      raddr = 5'd2;
      #1 check("dropped_wr", ram_data_out, 32'h0);

      // Reset in the middle of a clear sequence restarts it and forgets old contents.
      wr(0, 5'd9, 32'hCAFE);
      wr(1, 5'd10, 32'hF00D);
      tick();
      idle();
      raddr = 5'd9;
      #1 check("pre_rst_wr", ram_data_out, 32'hCAFE);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < 10; c++) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      for (int c = 0; c < DEPTH; c++) begin
         sample("reclear");
         tick();
      end
      #1 check("reclear_done", {{(WIDTH-1){1'b0}}, init_done}, 32'h1);
      raddr = 5'd9;
      sample("rst_wipe9");
      #1 check("wiped9", ram_data_out, 32'h0);
      raddr = 5'd10;
      sample("rst_wipe10");

      // Single ports replacing each other's value at one address.
      wr(0, 5'd5, 32'hDEADBEEF);
      tick();
      idle();
      wr(1, 5'd5, 32'h12345678);
      tick();
      idle();
      raddr = 5'd5;
      sample("p1_over_p0");
      #1 check("p1_value", ram_data_out, 32'h12345678);
      wr(0, 5'd5, 32'h1);
      tick();
      idle();
      sample("p0_over_p1");
      #1 check("p0_value", ram_data_out, 32'h1);

      // Same-cycle collision: higher port wins.
      wr(0, 5'd7, 32'hAAAA);
      wr(1, 5'd7, 32'hBBBB);
      tick();
      idle();
      raddr = 5'd7;
      sample("collision");
      #1 check("collision_val", ram_data_out, 32'hBBBB);

      // Read during write returns the old value until the next cycle.
      raddr = 5'd3;
      wr(0, 5'd3, 32'h55);
      sample("rdw_old");
      #1 check("rdw_old_val", ram_data_out, 32'h0);
      tick();
      idle();
      sample("rdw_new");
      #1 check("rdw_new_val", ram_data_out, 32'h55);

      // Random traffic on a narrow address range to provoke collisions and read-during-write.
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < NWP; p++) begin
            ram_write[p]    = 1'($urandom_range(0, 1));
            waddr[p]        = AW'($urandom_range(0, 7));
            new_ram_data[p] = WIDTH'($urandom);
         end
         raddr = AW'($urandom_range(0, 9));
         sample("rand");
         tick();
      end
      idle();
      for (int a = 0; a < DEPTH; a++) begin
         raddr = AW'(a);
         sample("final_rd");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
